// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity mode codes and the 3-sample majority helper.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Majority of three samples: a single corrupted sample never flips the bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_sampler.sv
// Line front end: 2-FF synchroniser for the asynchronous rx line plus the
// mid-bit sample registers feeding a 3-sample majority vote. The vote output
// is meaningful on the tick where tick_cnt == MID+1 (third sample is live rx_s).
module uart_rx_cfg_sampler
  import uart_rx_cfg_pkg::*;
#(
  parameter int TICK_W = 4,
  parameter int MID    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic [TICK_W-1:0] i_tick_cnt,
  input  logic              i_rx,
  output logic              o_rx_s,
  output logic              o_vote
);

  logic       sync_reg;
  logic       rx_s_reg;
  logic [1:0] samp_bits;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_reg <= 1'b1;
      rx_s_reg <= 1'b1;
    end else begin
      sync_reg <= i_rx;
      rx_s_reg <= sync_reg;
    end
  end

  // Sample slots at ticks MID-1 and MID; the MID+1 sample is taken live.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_samp
      localparam logic [TICK_W-1:0] SAMP_AT = TICK_W'(MID - 1 + gi);
      logic samp_reg;

      // Capture the synchronised line at this slot's tick.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          samp_reg <= 1'b1;
        end else if (i_tick && (i_tick_cnt == SAMP_AT)) begin
          samp_reg <= rx_s_reg;
        end
      end

      assign samp_bits[gi] = samp_reg;
    end
  endgenerate

  assign o_rx_s = rx_s_reg;
  assign o_vote = maj3(samp_bits[0], samp_bits[1], rx_s_reg);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled start detection with false-start
// rejection, majority-voted data/parity/stop bits, and parity, framing and
// break reporting. A frame completes at mid-point of its last stop bit so the
// receiver tolerates baud drift and is ready early for the next start edge.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int OVS       = 16,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done_tick,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break
);

  localparam int MID    = OVS / 2;
  localparam int TICK_W = $clog2(OVS);
  localparam int BIT_W  = $clog2(NB_DATA);

  localparam logic [TICK_W-1:0] VOTE_TICK = TICK_W'(MID + 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVS - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NB_DATA - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_t          state_reg;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic               stop_idx_reg;
  logic [NB_DATA-1:0] shift_reg;
  logic               par_acc_reg;
  logic               pbit_reg;
  logic               stop_err_reg;
  logic               armed_reg;

  logic [NB_DATA-1:0] data_reg;
  logic               done_reg;
  logic               parity_err_reg;
  logic               frame_err_reg;
  logic               break_reg;

  logic rx_s;
  logic vote;
  logic at_vote;
  logic at_last;
  logic frame_err_now;
  logic parity_bad;

  uart_rx_cfg_sampler #(
    .TICK_W (TICK_W),
    .MID    (MID)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_s_tick),
    .i_tick_cnt (tick_cnt_reg),
    .i_rx       (i_rx),
    .o_rx_s     (rx_s),
    .o_vote     (vote)
  );

  assign at_vote       = (tick_cnt_reg == VOTE_TICK);
  assign at_last       = (tick_cnt_reg == LAST_TICK);
  // Framing error accumulates over all stop bits including the current vote.
  assign frame_err_now = stop_err_reg | ~vote;
  assign parity_bad    = (PARITY != PARITY_NONE) &&
                         ((par_acc_reg ^ pbit_reg) != (PARITY == PARITY_ODD));

  // Receive FSM with counters, shift register and registered result outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg      <= RX_IDLE;
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      stop_idx_reg   <= 1'b0;
      shift_reg      <= '0;
      par_acc_reg    <= 1'b0;
      pbit_reg       <= 1'b0;
      stop_err_reg   <= 1'b0;
      armed_reg      <= 1'b1;
      data_reg       <= '0;
      done_reg       <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      break_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (i_s_tick) begin
        tick_cnt_reg <= at_last ? '0 : tick_cnt_reg + TICK_W'(1);
        case (state_reg)
          RX_IDLE: begin
            tick_cnt_reg <= '0;
            if (!armed_reg) begin
              // After a framing error, wait for the line to go idle again.
              if (rx_s) armed_reg <= 1'b1;
            end else if (!rx_s) begin
              state_reg    <= RX_START;
              shift_reg    <= '0;
              par_acc_reg  <= 1'b0;
              pbit_reg     <= 1'b0;
              stop_err_reg <= 1'b0;
              stop_idx_reg <= 1'b0;
            end
          end

          RX_START: begin
            if (at_vote && vote) begin
              // Start bit did not survive to mid-bit: treat as noise.
              state_reg    <= RX_IDLE;
              tick_cnt_reg <= '0;
            end else if (at_last) begin
              state_reg   <= RX_DATA;
              bit_cnt_reg <= '0;
            end
          end

          RX_DATA: begin
            if (at_vote) begin
              shift_reg   <= {vote, shift_reg[NB_DATA-1:1]};
              par_acc_reg <= par_acc_reg ^ vote;
            end
            if (at_last) begin
              if (bit_cnt_reg == LAST_BIT) begin
                state_reg <= (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
              end
            end
          end

          RX_PARITY: begin
            if (at_vote) pbit_reg <= vote;
            if (at_last) state_reg <= RX_STOP;
          end

          RX_STOP: begin
            if (at_vote) begin
              if (stop_idx_reg == LAST_STOP) begin
                // Finish at mid-stop and publish the frame with its flags.
                done_reg       <= 1'b1;
                data_reg       <= shift_reg;
                parity_err_reg <= parity_bad;
                frame_err_reg  <= frame_err_now;
                break_reg      <= frame_err_now && (shift_reg == '0) &&
                                  ((PARITY == PARITY_NONE) || !pbit_reg);
                armed_reg      <= !frame_err_now;
                state_reg      <= RX_IDLE;
                tick_cnt_reg   <= '0;
              end else begin
                stop_err_reg <= frame_err_now;
              end
            end else if (at_last) begin
              stop_idx_reg <= 1'b1;
            end
          end

          default: begin
            state_reg    <= RX_IDLE;
            tick_cnt_reg <= '0;
          end
        endcase
      end
    end
  end

  assign o_rx_data      = data_reg;
  assign o_rx_done_tick = done_reg;
  assign o_parity_err   = parity_err_reg;
  assign o_frame_err    = frame_err_reg;
  assign o_break        = break_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg. Three receivers share clock, reset and tick:
// a: even parity, 1 stop; b: odd parity, 1 stop; c: even parity, 2 stops.
// Each receiver sees the driven line only when its line_en bit is set.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       tick = 1'b0;
  logic       rx   = 1'b1;
  logic [2:0] line_en = 3'b001;

  logic rx_a, rx_b, rx_c;
  assign rx_a = line_en[0] ? rx : 1'b1;
  assign rx_b = line_en[1] ? rx : 1'b1;
  assign rx_c = line_en[2] ? rx : 1'b1;

  logic [7:0] data_a, data_b, data_c;
  logic done_a, perr_a, ferr_a, brk_a;
  logic done_b, perr_b, ferr_b, brk_b;
  logic done_c, perr_c, ferr_c, brk_c;

  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int done_cnt_c = 0;
  int n_checks   = 0;
  int n_pass     = 0;
  int base;

  uart_rx_cfg #(.NB_DATA(8), .OVS(16), .PARITY(1), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx_a),
    .o_rx_data(data_a), .o_rx_done_tick(done_a), .o_parity_err(perr_a),
    .o_frame_err(ferr_a), .o_break(brk_a)
  );

  uart_rx_cfg #(.NB_DATA(8), .OVS(16), .PARITY(2), .STOP_BITS(1)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx_b),
    .o_rx_data(data_b), .o_rx_done_tick(done_b), .o_parity_err(perr_b),
    .o_frame_err(ferr_b), .o_break(brk_b)
  );

  uart_rx_cfg #(.NB_DATA(8), .OVS(16), .PARITY(1), .STOP_BITS(2)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_s_tick(tick), .i_rx(rx_c),
    .o_rx_data(data_c), .o_rx_done_tick(done_c), .o_parity_err(perr_c),
    .o_frame_err(ferr_c), .o_break(brk_c)
  );

  always #5 clk = ~clk;

  // Oversampling strobe: one clock high out of every three.
  initial begin : tick_gen
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      tick = (k == 2);
      k = (k == 2) ? 0 : k + 1;
    end
  end

  always @(posedge clk) begin
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (done_c) done_cnt_c <= done_cnt_c + 1;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %s: got 0x%0h expected 0x%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic val, input int n);
    @(negedge clk);
    rx = val;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit,
                            input logic stop0, input logic stop1, input int nstop);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(data[i], 16);
    drive_bit(pbit, 16);
    drive_bit(stop0, 16);
    if (nstop == 2) drive_bit(stop1, 16);
  endtask

  initial begin : stim
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_a", {4'h0, data_a, done_a, perr_a, ferr_a, brk_a}, 16'h0);
    check("rst_out_c", {4'h0, data_c, done_c, perr_c, ferr_c, brk_c}, 16'h0);
    rst = 1'b0;
    drive_bit(1'b1, 32);

    // 1: 0x55 then back-to-back 0xA3, even parity correct
    base = done_cnt_a;
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1);
    @(negedge clk);
    check("t1_data55", 16'(data_a), 16'h55);
    check("t1_flags55", {13'h0, perr_a, ferr_a, brk_a}, 16'h0);
    check("t1_done55", 16'(done_cnt_a - base), 16'd1);
    send_frame(8'hA3, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t1_dataA3", 16'(data_a), 16'hA3);
    check("t1_doneA3", 16'(done_cnt_a - base), 16'd2);

    // 2: 4-tick low glitch is a false start, next frame still good
    base = done_cnt_a;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 48);
    @(negedge clk);
    check("t2_glitch_done", 16'(done_cnt_a - base), 16'd0);
    send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t2_data0F", 16'(data_a), 16'h0F);
    check("t2_done0F", 16'(done_cnt_a - base), 16'd1);

    // 3: 0xA3 with parity bit 1: wrong for even, right for odd
    line_en = 3'b011;
    base = done_cnt_b;
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t3_even_data", 16'(data_a), 16'hA3);
    check("t3_even_flags", {13'h0, perr_a, ferr_a, brk_a}, 16'h4);
    check("t3_odd_data", 16'(data_b), 16'hA3);
    check("t3_odd_flags", {13'h0, perr_b, ferr_b, brk_b}, 16'h0);
    check("t3_odd_done", 16'(done_cnt_b - base), 16'd1);

    // 4: break for 3 frame times gives one pulse, then 0x81 clean
    line_en = 3'b001;
    base = done_cnt_a;
    drive_bit(1'b0, 528);
    @(negedge clk);
    check("t4_brk_done", 16'(done_cnt_a - base), 16'd1);
    check("t4_brk_flags", {13'h0, perr_a, ferr_a, brk_a}, 16'h3);
    check("t4_brk_data", 16'(data_a), 16'h00);
    drive_bit(1'b1, 32);
    base = done_cnt_a;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t4_data81", 16'(data_a), 16'h81);
    check("t4_flags81", {13'h0, perr_a, ferr_a, brk_a}, 16'h0);
    check("t4_done81", 16'(done_cnt_a - base), 16'd1);

    // 5a: one-tick low spike at MID of data bit 3 of 0xFF is outvoted
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 16);
    drive_bit(1'b1, 9);
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 6);
    for (int i = 4; i < 8; i++) drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t5_dataFF", 16'(data_a), 16'hFF);
    check("t5_flagsFF", {13'h0, perr_a, ferr_a, brk_a}, 16'h0);

    // 5b: two stop bits, good frame then second stop bit low
    line_en = 3'b100;
    base = done_cnt_c;
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 2);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t5_s2_data96", 16'(data_c), 16'h96);
    check("t5_s2_flags96", {13'h0, perr_c, ferr_c, brk_c}, 16'h0);
    check("t5_s2_done96", 16'(done_cnt_c - base), 16'd1);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 2);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t5_s2_data55", 16'(data_c), 16'h55);
    check("t5_s2_ferr", {13'h0, perr_c, ferr_c, brk_c}, 16'h2);

    // 6: reset during data bit 4 of 0x3C, then 0x3C again
    line_en = 3'b001;
    base = done_cnt_a;
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("t6_rst_out", {4'h0, data_a, done_a, perr_a, ferr_a, brk_a}, 16'h0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 48);
    @(negedge clk);
    check("t6_abort_done", 16'(done_cnt_a - base), 16'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1);
    drive_bit(1'b1, 32);
    @(negedge clk);
    check("t6_data3C", 16'(data_a), 16'h3C);
    check("t6_flags3C", {13'h0, perr_a, ferr_a, brk_a}, 16'h0);
    check("t6_done3C", 16'(done_cnt_a - base), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
